// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard control unit:
// writeback select of loads, forward-select encodings and FSM states.
package hazard_pkg;

    localparam logic [1:0] WB_LD  = 2'b01;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_W  = 2'b01;

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_t;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// fwd_unit: combinational E-stage operand forward select for one source
// operand. The M stage takes priority over W; x0 never forwards.
import hazard_pkg::*;

module fwd_unit (
    input  logic [4:0] rs_addr,
    input  logic [4:0] rd_addrM,
    input  logic       rd_wrenM,
    input  logic [4:0] rd_addrW,
    input  logic       rd_wrenW,
    output logic [1:0] fwd
);

    // Pick the youngest in-flight producer of rs_addr.
    always_comb begin
        fwd = FWD_RF;
        if (rd_wrenM && (rd_addrM != '0) && (rd_addrM == rs_addr))
            fwd = FWD_M;
        else if (rd_wrenW && (rd_addrW != '0) && (rd_addrW == rs_addr))
            fwd = FWD_W;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush control for the F/D, D/E, E/M and M/W pipeline
// registers plus E-stage forwarding selects. A two-state FSM with a timeout
// counter sequences multi-cycle data-memory accesses.
// Optional macro HAZARD_PERF_CNT_EN adds saturating performance counters.
import hazard_pkg::*;

module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [4:0]       rs1_addrD,
    input  logic [4:0]       rs2_addrD,
    input  logic [4:0]       rs1_addrE,
    input  logic [4:0]       rs2_addrE,
    input  logic [4:0]       rd_addrE,
    input  logic             rd_wrenE,
    input  logic [1:0]       wb_selE,
    input  logic             pc_selE,
    input  logic [4:0]       rd_addrM,
    input  logic             rd_wrenM,
    input  logic             lsu_reqM,
    input  logic             lsu_ackM,
    input  logic [4:0]       rd_addrW,
    input  logic             rd_wrenW,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             StallW,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FlushW,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             mem_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_lu_stalls,
    output logic [CNT_W-1:0] perf_mem_stalls,
    output logic [CNT_W-1:0] perf_flushes
`endif
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             timeout;
    logic             mem_stall;
    logic             load_use;
    logic             branch;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;

    fwd_unit u_fwd_a (
        .rs_addr  (rs1_addrE),
        .rd_addrM (rd_addrM),
        .rd_wrenM (rd_wrenM),
        .rd_addrW (rd_addrW),
        .rd_wrenW (rd_wrenW),
        .fwd      (fwd_a)
    );

    fwd_unit u_fwd_b (
        .rs_addr  (rs2_addrE),
        .rd_addrM (rd_addrM),
        .rd_wrenM (rd_wrenM),
        .rd_addrW (rd_addrW),
        .rd_wrenW (rd_wrenW),
        .fwd      (fwd_b)
    );

    // Hazard conditions; the timeout cycle releases the pipeline like an ack.
    always_comb begin
        timeout   = (state == MEM_WAIT) && !lsu_ackM && (count == TIMEOUT_LAST);
        mem_stall = ((state == MEM_WAIT) && !lsu_ackM && !timeout) ||
                    ((state == RUN) && lsu_reqM && !lsu_ackM);
        load_use  = rd_wrenE && (wb_selE == WB_LD) && (rd_addrE != '0) &&
                    ((rd_addrE == rs1_addrD) || (rd_addrE == rs2_addrD));
        branch    = pc_selE;
    end

    // Prioritised stall/flush outputs, all forced low while reset is held.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        StallW    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        FlushW    = 1'b0;
        forwardAE = FWD_RF;
        forwardBE = FWD_RF;
        mem_err   = 1'b0;
        if (i_rst_n) begin
            forwardAE = fwd_a;
            forwardBE = fwd_b;
            mem_err   = timeout;
            if (mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (branch) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (load_use) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    // Memory-wait FSM and timeout counter; lsu_reqM is ignored in MEM_WAIT.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= RUN;
            count <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (lsu_reqM && !lsu_ackM) begin
                        state <= MEM_WAIT;
                        count <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (lsu_ackM || (count == TIMEOUT_LAST))
                        state <= RUN;
                    else
                        count <= count + CNT_W'(1);
                end
                default: begin
                    state <= RUN;
                    count <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic lu_active;
    logic flush_active;

    // Only the winning priority level counts as an event.
    always_comb begin
        lu_active    = !mem_stall && !branch && load_use;
        flush_active = !mem_stall && branch;
    end

    // Saturating performance counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            perf_lu_stalls  <= '0;
            perf_mem_stalls <= '0;
            perf_flushes    <= '0;
        end else begin
            if (lu_active && (perf_lu_stalls != '1))
                perf_lu_stalls <= perf_lu_stalls + CNT_W'(1);
            if (mem_stall && (perf_mem_stalls != '1))
                perf_mem_stalls <= perf_mem_stalls + CNT_W'(1);
            if (flush_active && (perf_flushes != '1))
                perf_flushes <= perf_flushes + CNT_W'(1);
        end
    end
`endif

endmodule
